// File: rtl/nios_processor_adc_capture_if.sv
// rtl/nios_processor_adc_capture_if.sv - serial ADC pin bundle for the ADC capture block
interface nios_processor_adc_capture_if;
    logic adc_convst;
    logic adc_sclk;
    logic adc_din;
    logic adc_dout;

    modport master (
        output adc_convst,
        output adc_sclk,
        output adc_din,
        input  adc_dout
    );

    modport slave (
        input  adc_convst,
        input  adc_sclk,
        input  adc_din,
        output adc_dout
    );
endinterface

// File: rtl/nios_processor_adc_capture.sv
// rtl/nios_processor_adc_capture.sv - PIO-fed serial ADC sequencer; optional 4-frame averaging under ADC_CAPTURE_AVG_EN
module nios_processor_adc_capture #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [15:0]                         ctrl,
    output logic [15:0]                         sample,
    nios_processor_adc_capture_if.master        adc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [9:0] CONV_LAST = 10'(CONV_CYCLES - 1);
    localparam logic [4:0] HP_END    = 5'd24;

    logic [1:0]  state_q, state_d;
    logic [9:0]  conv_cnt_q, conv_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [4:0]  hp_cnt_q, hp_cnt_d;
    logic [11:0] shreg_q, shreg_d;
    logic [2:0]  ch_q, ch_d;
    logic [15:0] sample_q, sample_d;
    logic        convst_q, convst_d;
    logic        sclk_q, sclk_d;
    logic        din_q, din_d;

    logic [5:0]  cfg_w;
    logic [5:0]  cfg_sh;
    logic [4:0]  hp_next;
    logic [4:0]  next_period;

`ifdef ADC_CAPTURE_AVG_EN
    logic [13:0] acc_q, acc_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic [2:0]  prev_ch_q, prev_ch_d;
    logic        restart;
    logic [13:0] sum;
    logic [2:0]  nfr;
`endif

    assign cfg_w       = {1'b1, ch_q[0], ch_q[2], ch_q[1], 1'b1, 1'b0};
    assign hp_next     = hp_cnt_q + 5'd1;
    assign next_period = hp_next >> 1;
    // Shifting past bit 5 yields zero, so periods 7..12 drive din low for free.
    assign cfg_sh      = cfg_w << next_period;

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        div_cnt_d  = div_cnt_q;
        hp_cnt_d   = hp_cnt_q;
        shreg_d    = shreg_q;
        ch_d       = ch_q;
        sample_d   = sample_q;
        convst_d   = 1'b0;
        sclk_d     = sclk_q;
        din_d      = din_q;
`ifdef ADC_CAPTURE_AVG_EN
        acc_d      = acc_q;
        fcnt_d     = fcnt_q;
        prev_ch_d  = prev_ch_q;
        restart    = 1'b0;
        sum        = 14'd0;
        nfr        = 3'd0;
`endif
        case (state_q)
            S_IDLE: begin
                sclk_d = 1'b0;
                din_d  = 1'b0;
                if (ctrl[0]) begin
                    state_d    = S_CONV;
                    ch_d       = ctrl[3:1];
                    convst_d   = 1'b1;
                    conv_cnt_d = 10'd0;
                end
            end
            S_CONV: begin
                if (conv_cnt_q == CONV_LAST) begin
                    state_d   = S_SHIFT;
                    div_cnt_d = 8'd0;
                    hp_cnt_d  = 5'd0;
                    sclk_d    = 1'b0;
                    din_d     = cfg_w[5];
                end else begin
                    conv_cnt_d = conv_cnt_q + 10'd1;
                end
            end
            S_SHIFT: begin
                if (hp_cnt_q == HP_END) begin
                    state_d = S_DONE;
                    sclk_d  = 1'b0;
                    din_d   = 1'b0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = 8'd0;
                    hp_cnt_d  = hp_next;
                    sclk_d    = ~sclk_q;
                    // Capture on the rising edge; advance din on the falling edge.
                    if (!sclk_q) begin
                        shreg_d = {shreg_q[10:0], adc.adc_dout};
                    end else begin
                        din_d = cfg_sh[5];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
`ifdef ADC_CAPTURE_AVG_EN
                restart   = (ch_q != prev_ch_q);
                sum       = (restart ? 14'd0 : acc_q) + {2'b00, shreg_q};
                nfr       = (restart ? 3'd0 : {1'b0, fcnt_q}) + 3'd1;
                prev_ch_d = ch_q;
                if (nfr == 3'd4) begin
                    sample_d = {~sample_q[15], ch_q, sum[13:2]};
                    acc_d    = 14'd0;
                    fcnt_d   = 2'd0;
                end else begin
                    acc_d  = sum;
                    fcnt_d = nfr[1:0];
                end
                if (!ctrl[0]) begin
                    acc_d  = 14'd0;
                    fcnt_d = 2'd0;
                end
`else
                sample_d = {~sample_q[15], ch_q, shreg_q};
`endif
                if (ctrl[0]) begin
                    state_d    = S_CONV;
                    ch_d       = ctrl[3:1];
                    convst_d   = 1'b1;
                    conv_cnt_d = 10'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            conv_cnt_q <= 10'd0;
            div_cnt_q  <= 8'd0;
            hp_cnt_q   <= 5'd0;
            shreg_q    <= 12'd0;
            ch_q       <= 3'd0;
            sample_q   <= 16'h0000;
            convst_q   <= 1'b0;
            sclk_q     <= 1'b0;
            din_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            div_cnt_q  <= div_cnt_d;
            hp_cnt_q   <= hp_cnt_d;
            shreg_q    <= shreg_d;
            ch_q       <= ch_d;
            sample_q   <= sample_d;
            convst_q   <= convst_d;
            sclk_q     <= sclk_d;
            din_q      <= din_d;
        end
    end

`ifdef ADC_CAPTURE_AVG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= 14'd0;
            fcnt_q    <= 2'd0;
            prev_ch_q <= 3'd0;
        end else begin
            acc_q     <= acc_d;
            fcnt_q    <= fcnt_d;
            prev_ch_q <= prev_ch_d;
        end
    end
`endif

    assign sample         = sample_q;
    assign adc.adc_convst = convst_q;
    assign adc.adc_sclk   = sclk_q;
    assign adc.adc_din    = din_q;

endmodule
